// File: rtl/clb_tile_if.sv
// rtl/clb_tile_if.sv - configuration write port and neighbour signals of one CLB tile
interface clb_tile_if;
    logic        wr_en;
    logic [22:0] bits;
    logic        up_i;
    logic        down_i;
    logic        right_i;
    logic        left_i;
    logic        up_o;
    logic        down_o;
    logic        right_o;
    logic        left_o;

    // master drives config and neighbour inputs; slave is the tile itself
    modport master (
        output wr_en, bits, up_i, down_i, right_i, left_i,
        input  up_o, down_o, right_o, left_o
    );

    modport slave (
        input  wr_en, bits, up_i, down_i, right_i, left_i,
        output up_o, down_o, right_o, left_o
    );
endinterface

// File: rtl/clb_tile.sv
// rtl/clb_tile.sv - CLB tile: 4-input LUT with per-side pass-through/LUT output muxes
// Optional cfg_o readback port enabled by CLB_CFG_READBACK_EN.
module clb_tile #(
    parameter logic [22:0] RESET_CFG = 23'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
`ifdef CLB_CFG_READBACK_EN
    output logic [22:0] cfg_o,
`endif
    clb_tile_if.slave   tile
);
    logic [22:0] cfg;
    logic [15:0] lut_tbl;
    logic        comb_mode;
    logic        left_sel;
    logic        right_sel;
    logic        down_sel;
    logic        up_sel;
    logic [3:0]  lut_idx;
    logic        lut_raw;
    logic        lut_q;
    logic        lut_out;
    logic        reserved_unused;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg <= RESET_CFG;
        end else if (tile.wr_en) begin
            cfg <= tile.bits;
        end
    end

    assign lut_tbl         = cfg[15:0];
    assign reserved_unused = ^cfg[17:16];
    assign comb_mode       = cfg[18];
    assign left_sel        = cfg[19];
    assign right_sel       = cfg[20];
    assign down_sel        = cfg[21];
    assign up_sel          = cfg[22];

    assign lut_idx = {tile.up_i, tile.down_i, tile.right_i, tile.left_i};
    assign lut_raw = lut_tbl[lut_idx];

    // samples with the cfg in force before the edge, so a same-edge write
    // only affects the value captured on the following edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lut_q <= 1'b0;
        end else begin
            lut_q <= lut_raw;
        end
    end

    assign lut_out = comb_mode ? lut_raw : lut_q;

    assign tile.up_o    = up_sel    ? lut_out : tile.down_i;
    assign tile.down_o  = down_sel  ? lut_out : tile.up_i;
    assign tile.right_o = right_sel ? lut_out : tile.left_i;
    assign tile.left_o  = left_sel  ? lut_out : tile.right_i;

`ifdef CLB_CFG_READBACK_EN
    assign cfg_o = cfg;
`endif
endmodule

// File: tb/tb_clb_tile.sv
// tb/tb_clb_tile.sv - directed self-checking bench for clb_tile
module tb_clb_tile;
    logic clk_i = 1'b0;
    logic rst_i;
    int   tests_run = 0;
    int   tests_failed = 0;

    clb_tile_if ifc ();

`ifdef CLB_CFG_READBACK_EN
    logic [22:0] cfg_o;
    clb_tile #(.RESET_CFG(23'h0)) dut (.clk_i(clk_i), .rst_i(rst_i), .cfg_o(cfg_o), .tile(ifc));
`else
    clb_tile #(.RESET_CFG(23'h0)) dut (.clk_i(clk_i), .rst_i(rst_i), .tile(ifc));
`endif

    always #5 clk_i = ~clk_i;

    // outputs packed as {up_o, down_o, right_o, left_o}
    function automatic logic [3:0] outs();
        return {ifc.up_o, ifc.down_o, ifc.right_o, ifc.left_o};
    endfunction

    task automatic check(input string tag, input logic [22:0] obs, input logic [22:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic u, input logic d, input logic r, input logic l);
        ifc.up_i = u;
        ifc.down_i = d;
        ifc.right_i = r;
        ifc.left_i = l;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_cfg(input logic [22:0] b);
        @(negedge clk_i);
        ifc.bits = b;
        ifc.wr_en = 1'b1;
        @(posedge clk_i);
        #1;
        ifc.wr_en = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        ifc.wr_en = 1'b0;
        ifc.bits = 23'h0;
        set_in(1, 0, 1, 0);
        check("reset_passthru", {19'h0, outs()}, 23'h5);
        check("reset_lut_q", {22'h0, dut.lut_q}, 23'h0);

        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
        tick();
        check("idle_passthru", {19'h0, outs()}, 23'h5);

        // pass-through with reserved bits set
        write_cfg(23'b0000_0_11_0101001000110111);
        set_in(1, 1, 0, 1);
        check("pt_1101", {19'h0, outs()}, 23'he);
        set_in(0, 1, 1, 0);
        check("pt_0110", {19'h0, outs()}, 23'h9);
`ifdef CLB_CFG_READBACK_EN
        check("readback", cfg_o, 23'b0000_0_11_0101001000110111);
`endif

        // combinational, down/right from LUT
        write_cfg({7'b0110_1_10, 16'b0101101000110111});
        set_in(1, 1, 0, 1);
        check("comb_1101", {19'h0, outs()}, 23'h8);
        set_in(0, 0, 0, 1);
        check("comb_0001", {19'h0, outs()}, 23'h6);
        set_in(1, 1, 1, 1);
        check("comb_1111", {19'h0, outs()}, 23'h9);
        set_in(0, 0, 0, 1);

        // registered, all from LUT; write edge samples old LUT (idx1 = 1)
        write_cfg({7'b1111_0_00, 16'hFF00});
        check("wr_edge_old_lut", {19'h0, outs()}, 23'hf);
        tick();
        check("reg_0001", {19'h0, outs()}, 23'h0);
        @(negedge clk_i);
        set_in(1, 1, 0, 1);
        check("reg_hold_low", {19'h0, outs()}, 23'h0);
        tick();
        check("reg_1101", {19'h0, outs()}, 23'hf);
        @(negedge clk_i);
        set_in(0, 0, 0, 1);
        check("reg_hold_high", {19'h0, outs()}, 23'hf);
        tick();
        check("reg_back_0001", {19'h0, outs()}, 23'h0);

        // bits change without wr_en must not reconfigure
        @(negedge clk_i);
        ifc.bits = 23'h0;
        set_in(1, 1, 0, 1);
        tick();
        tick();
        check("no_wr_en", {19'h0, outs()}, 23'hf);
        check("no_wr_en_cfg", dut.cfg, {7'b1111_0_00, 16'hFF00});

        // async reset between edges with lut_q = 1
        @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_lut_q", {22'h0, dut.lut_q}, 23'h0);
        check("arst_cfg", dut.cfg, 23'h0);
        check("arst_passthru", {19'h0, outs()}, 23'he);
        ifc.bits = 23'h7fffff;
        ifc.wr_en = 1'b1;
        tick();
        check("arst_blocks_wr", dut.cfg, 23'h0);
`ifdef CLB_CFG_READBACK_EN
        check("arst_readback", cfg_o, 23'h0);
`endif
        @(negedge clk_i);
        ifc.wr_en = 1'b0;
        rst_i = 1'b0;
        tick();
        check("post_rst_passthru", {19'h0, outs()}, 23'he);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
